// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte over valid/ready and shifts it out
// as start, DATA_BITS data bits (LSB first), optional parity, 1 or 2 stop bits.
// Each line state lasts i_DIVISOR+1 clocks, timed by an internal bit counter.
//
// Ports:
//   P_CLK        system clock, rising edge
//   reset        synchronous active-high reset
//   i_DIVISOR    bit period minus one (sampled at accept)
//   i_PARITY_EN  insert parity bit (sampled at accept)
//   i_PARITY_ODD odd parity when 1, even when 0 (sampled at accept)
//   i_STOP2      two stop bits when 1 (sampled at accept)
//   i_DATA       byte to send (sampled at accept)
//   i_VALID      host offers a byte
//   o_READY      block can accept (IDLE only)
//   o_TX         serial line, idle high
//   o_BUSY       frame in progress
//   o_DONE       one-cycle pulse on the first IDLE cycle after a frame
module uart_tx_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 P_CLK,
  input  logic                 reset,
  input  logic [CNT_BITS-1:0]  i_DIVISOR,
  input  logic                 i_PARITY_EN,
  input  logic                 i_PARITY_ODD,
  input  logic                 i_STOP2,
  input  logic [DATA_BITS-1:0] i_DATA,
  input  logic                 i_VALID,
  output logic                 o_READY,
  output logic                 o_TX,
  output logic                 o_BUSY,
  output logic                 o_DONE
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic [IDX_W-1:0]      idx_nxt;

  // State and datapath registers
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, bit timer and registered output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    tick      = (cnt_q == div_q);
    idx_nxt   = idx_q + IDX_W'(1);

    // Counter free-runs outside IDLE and wraps on each bit boundary
    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CNT_BITS'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_VALID) begin
          data_d    = i_DATA;
          div_d     = i_DIVISOR;
          par_en_d  = i_PARITY_EN;
          par_odd_d = i_PARITY_ODD;
          stop2_d   = i_STOP2;
          cnt_d     = '0;
          idx_d     = '0;
          tx_d      = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q != IDX_W'(DATA_BITS - 1)) begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end else if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = (^data_q) ^ par_odd_q;
          end else begin
            state_d = S_STOP1;
            tx_d    = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP1;
          tx_d    = 1'b1;
        end
      end
      S_STOP1: begin
        if (tick) begin
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign o_TX    = tx_q;
  assign o_READY = ready_q;
  assign o_BUSY  = busy_q;
  assign o_DONE  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl with hand-computed line sequences.
module tb_uart_tx_ctrl;

  logic        P_CLK = 1'b0;
  logic        reset;
  logic [15:0] i_DIVISOR;
  logic        i_PARITY_EN;
  logic        i_PARITY_ODD;
  logic        i_STOP2;
  logic [7:0]  i_DATA;
  logic        i_VALID;
  logic        o_READY;
  logic        o_TX;
  logic        o_BUSY;
  logic        o_DONE;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_ctrl #(.DATA_BITS(8), .CNT_BITS(16)) dut (
    .P_CLK       (P_CLK),
    .reset       (reset),
    .i_DIVISOR   (i_DIVISOR),
    .i_PARITY_EN (i_PARITY_EN),
    .i_PARITY_ODD(i_PARITY_ODD),
    .i_STOP2     (i_STOP2),
    .i_DATA      (i_DATA),
    .i_VALID     (i_VALID),
    .o_READY     (o_READY),
    .o_TX        (o_TX),
    .o_BUSY      (o_BUSY),
    .o_DONE      (o_DONE)
  );

  always #5 P_CLK = ~P_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge P_CLK);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [15:0] dv,
                         input logic pe, input logic po, input logic s2);
    i_DATA = d; i_DIVISOR = dv; i_PARITY_EN = pe; i_PARITY_ODD = po; i_STOP2 = s2;
  endtask

  // One-cycle valid pulse; returns in the first START cycle
  task automatic start_frame();
    i_VALID = 1'b1;
    step();
    i_VALID = 1'b0;
  endtask

  // seq[b] is the expected line level of bit slot b; returns in the o_DONE cycle
  task automatic body(input string tag, input logic [11:0] seq, input int nbits, input int dv);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c <= dv; c++) begin
        chk({tag, "_tx"}, 32'(o_TX), 32'(seq[b]));
        chk({tag, "_busy"}, 32'(o_BUSY), 32'd1);
        chk({tag, "_ready"}, 32'(o_READY), 32'd0);
        chk({tag, "_done_early"}, 32'(o_DONE), 32'd0);
        step();
      end
    end
    chk({tag, "_done"}, 32'(o_DONE), 32'd1);
    chk({tag, "_tx_idle"}, 32'(o_TX), 32'd1);
    chk({tag, "_ready_idle"}, 32'(o_READY), 32'd1);
    chk({tag, "_busy_idle"}, 32'(o_BUSY), 32'd0);
  endtask

  task automatic after_done(input string tag);
    step();
    chk({tag, "_done_once"}, 32'(o_DONE), 32'd0);
    chk({tag, "_tx_hold"}, 32'(o_TX), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    i_VALID = 1'b1;   // reset must win over a simultaneous valid
    set_cfg(8'hAA, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("rst_tx", 32'(o_TX), 32'd1);
    chk("rst_ready", 32'(o_READY), 32'd1);
    chk("rst_busy", 32'(o_BUSY), 32'd0);
    chk("rst_done", 32'(o_DONE), 32'd0);
    reset = 1'b0;
    i_VALID = 1'b0;
    step();
    chk("idle_tx", 32'(o_TX), 32'd1);
    chk("idle_busy", 32'(o_BUSY), 32'd0);

    // 0x55, div 3, 8N1: 0,1,0,1,0,1,0,1,0,1 x4 cycles = 40
    set_cfg(8'h55, 16'd3, 1'b0, 1'b0, 1'b0);
    start_frame();
    body("f55", 12'h2AA, 10, 3);
    after_done("f55");

    // 0x07, div 1, even parity: parity bit 1, 22 cycles
    set_cfg(8'h07, 16'd1, 1'b1, 1'b0, 1'b0);
    start_frame();
    body("par_even", 12'h60E, 11, 1);
    after_done("par_even");

    // Same byte, odd parity: parity bit 0
    set_cfg(8'h07, 16'd1, 1'b1, 1'b1, 1'b0);
    start_frame();
    body("par_odd", 12'h40E, 11, 1);
    after_done("par_odd");

    // 0xFF, div 2, two stop bits: low only for the 3 start cycles, 33 cycles
    set_cfg(8'hFF, 16'd2, 1'b0, 1'b0, 1'b1);
    start_frame();
    body("stop2", 12'h7FE, 11, 2);
    after_done("stop2");

    // Back-to-back with valid held: 0xA5 then 0x3C at div 0
    set_cfg(8'hA5, 16'd0, 1'b0, 1'b0, 1'b0);
    i_VALID = 1'b1;
    step();
    i_DATA = 8'h3C;
    body("b2b_a5", 12'h34A, 10, 0);
    step();
    i_VALID = 1'b0;
    body("b2b_3c", 12'h278, 10, 0);
    after_done("b2b_3c");

    // Reset during data bit 4 of 0x00 at div 3
    set_cfg(8'h00, 16'd3, 1'b0, 1'b0, 1'b0);
    start_frame();
    for (int c = 0; c < 20; c++) begin
      chk("abort_tx_low", 32'(o_TX), 32'd0);
      step();
    end
    chk("abort_in_bit4", 32'(o_BUSY), 32'd1);
    reset = 1'b1;
    i_VALID = 1'b1;
    step();
    reset = 1'b0;
    i_VALID = 1'b0;
    chk("abort_tx", 32'(o_TX), 32'd1);
    chk("abort_busy", 32'(o_BUSY), 32'd0);
    chk("abort_ready", 32'(o_READY), 32'd1);
    chk("abort_done", 32'(o_DONE), 32'd0);
    step();
    chk("abort_no_done", 32'(o_DONE), 32'd0);
    chk("abort_idle_busy", 32'(o_BUSY), 32'd0);
    set_cfg(8'h55, 16'd1, 1'b0, 1'b0, 1'b0);
    start_frame();
    body("post_abort", 12'h2AA, 10, 1);
    after_done("post_abort");

    // Inputs changed right after accept must not disturb the frame in flight
    set_cfg(8'h55, 16'd3, 1'b0, 1'b0, 1'b0);
    start_frame();
    set_cfg(8'h00, 16'd0, 1'b1, 1'b0, 1'b1);
    body("midchg", 12'h2AA, 10, 3);
    after_done("midchg");
    // New settings take effect on the next accept: 0x00, div 0, even parity, 2 stop
    start_frame();
    body("midchg_next", 12'hC00, 12, 0);
    after_done("midchg_next");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
